rst_seq: RTL
============

# rst_seq

Parametrised multi-channel reset sequencer; next generation of the single-output reset stretcher. Holds a bank of reset outputs asserted for a programmable time after reset, lock loss or a software request, then releases them one by one in ascending index order with a fixed gap. Sits at the SoC top level, driving subsystem resets such as memory controller, bus fabric, CPU and peripherals, in dependency order.

## Interface
- CHANNELS, 4, number of sequenced reset outputs (≥1)
- HOLD_CYCLES, 15, cycles all outputs stay asserted once lock is qualified (≥1)
- GAP_CYCLES, 8, cycles between consecutive channel releases (≥1)
- SYNC_STAGES, 2, flops in the lock_i synchroniser (≥2)

- clk_i  in  1  single clock; all logic on posedge
- rst_i  in  1  reset, synchronous, active-high
- lock_i  in  1  asynchronous PLL-lock / power-good level; present only with RST_SEQ_LOCK_EN
- sw_rst_i  in  1  synchronous software reset request, level-sampled each cycle
- rst_o  out  CHANNELS  active-high resets; bit 0 released first
- done_o  out  1  high once every channel is released

## Operation
- lock_s: lock_i through a SYNC_STAGES flop chain; the chain clears to 0 on rst_i. lock_s is constant 1 without the macro.
- restart = rst_i | sw_rst_i | ~lock_s.
- FSM states:
  - ASSERT: all rst_o = 1; cnt increments while lock_s = 1. At cnt == HOLD_CYCLES-1, go to RELEASE with idx = 0 and clear rst_o[0] on the same edge.
  - RELEASE: cnt counts GAP_CYCLES. At cnt == GAP_CYCLES-1, clear rst_o[idx+1] and increment idx. When idx reaches CHANNELS-1 and that bit has cleared, go to DONE on the next edge.
  - DONE: rst_o all 0, done_o = 1; hold until restart.
- Any state with restart = 1 → ASSERT on the next edge: all rst_o = 1, done_o = 0, cnt = 0, idx = 0.
- Released bits never re-assert individually; re-assertion is always all channels at once.
- sw_rst_i held high keeps the block in ASSERT with cnt = 0. Counting starts on the first edge after it falls.
- sw_rst_i and rst_i together behave as rst_i, which also clears the synchroniser.
- Reset values: rst_o = all 1, done_o = 0, state = ASSERT, cnt = 0, idx = 0, synchroniser = 0.
- Counter width is clog2(max(HOLD_CYCLES, GAP_CYCLES)+1). idx width is clog2(CHANNELS) with a minimum of 1.

## Timing
- Edge 1 is the first edge at which rst_i is sampled low.
- Without the macro: rst_o[0] falls at edge HOLD_CYCLES.
- With the macro and lock_i steady high: rst_o[0] falls at edge SYNC_STAGES+HOLD_CYCLES.
- rst_o[k] falls k·GAP_CYCLES edges after rst_o[0].
- done_o rises 1 edge after rst_o[CHANNELS-1] falls.
- CHANNELS = 1: done_o rises 1 edge after rst_o[0] falls.
- Restart latency from sampling restart: 1 edge to all-asserted outputs.
- Lock-loss latency from lock_i falling: SYNC_STAGES+1 edges.
- Outputs are registered; no combinational path from any input to rst_o or done_o.

## Configuration
- RST_SEQ_LOCK_EN defined: lock_i port and synchroniser are present. Lock loss forces ASSERT, and hold counting waits for lock.
- RST_SEQ_LOCK_EN undefined: no lock_i port and no synchroniser flops; lock_s is tied to 1.

## Structure
- Package rst_seq_pkg holds:
  - state encoding constants ST_ASSERT, ST_RELEASE, ST_DONE
  - the clog2 helper function
- Sub-module sync_bit: SYNC_STAGES-deep single-bit synchroniser with synchronous clear. Instantiated only under RST_SEQ_LOCK_EN.

## Test plan
All scenarios use defaults (CHANNELS=4, HOLD=15, GAP=8, SYNC=2).
- Macro off, rst_i high 3 cycles then low → rst_o = 4'hF through edge 14; then 4'hE at edge 15, 4'hC at 23, 4'h8 at 31, 4'h0 at 39; done_o = 1 at edge 40.
- Macro on, lock_i high throughout, same rst_i pulse → rst_o[0] falls at edge 17 and rst_o[3] at edge 41; done_o = 1 at edge 42.
- Macro on, lock_i low for 20 cycles after reset, then high → rst_o stays 4'hF; rst_o[0] falls 17 edges after lock_i rises.
- 1-cycle sw_rst_i pulse at edge 27 (rst_o = 4'hC) → rst_o = 4'hF, done_o = 0 at edge 28; rst_o[0] falls at edge 28+15 = 43.
- Lock_i drops while in DONE → rst_o = 4'hF and done_o = 0 three edges later. On lock return, full sequence restarts with the same spacing.
- rst_i asserted mid-RELEASE with sw_rst_i held high → outputs all 1; sequence starts only after both inputs are low.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the rst_seq reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Single-bit multi-flop synchroniser with synchronous clear.
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// Multi-channel reset sequencer: hold all resets, then release ascending with a fixed gap.
// Define RST_SEQ_LOCK_EN to add the lock_i port and its synchroniser.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned HOLD_CYCLES = 15,
  parameter int unsigned GAP_CYCLES  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
`ifdef RST_SEQ_LOCK_EN
  input  logic                lock_i,
`endif
  input  logic                sw_rst_i,
  output logic [CHANNELS-1:0] rst_o,
  output logic                done_o
);

  localparam int unsigned CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = clog2(CNT_MAX + 1);
  localparam int unsigned IDX_W   = (CHANNELS > 1) ? clog2(CHANNELS) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(CHANNELS - 1);

  if (CHANNELS < 1 || HOLD_CYCLES < 1 || GAP_CYCLES < 1 || SYNC_STAGES < 2) begin : g_param_check
    $error("rst_seq: illegal parameter value");
  end

  logic lock_s;
  logic restart;

`ifdef RST_SEQ_LOCK_EN
  sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .d_i   (lock_i),
    .q_o   (lock_s)
  );
`else
  assign lock_s = 1'b1;
`endif

  assign restart = rst_i | sw_rst_i | ~lock_s;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic [IDX_W-1:0]    idx_q,   idx_d;
  logic [CHANNELS-1:0] rst_q,   rst_d;
  logic                done_q,  done_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
    end
  end

  // Outputs are computed as next-state values and registered, so no input reaches them combinationally.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    done_d  = done_q;

    if (restart) begin
      state_d = ST_ASSERT;
      cnt_d   = '0;
      idx_d   = '0;
      rst_d   = '1;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_ASSERT: begin
          rst_d  = '1;
          done_d = 1'b0;
          if (cnt_q == HOLD_LAST) begin
            state_d  = ST_RELEASE;
            cnt_d    = '0;
            idx_d    = '0;
            rst_d[0] = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_RELEASE: begin
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
            rst_d   = '0;
            done_d  = 1'b1;
          end else if (cnt_q == GAP_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + IDX_W'(1);
            // Released bits form a contiguous low run, so a left shift clears exactly bit idx+1.
            rst_d = rst_q << 1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_DONE: begin
          rst_d  = '0;
          done_d = 1'b1;
        end

        default: begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
          idx_d   = '0;
          rst_d   = '1;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  assign rst_o  = rst_q;
  assign done_o = done_q;

endmodule
